// File: rtl/cla6_chain_seq_if.sv
// Request/result handshake bundle for the chunked wide-add sequencer.
//   master : requester side, drives req_* operands and res_ready
//   slave  : sequencer side, drives req_ready and res_* results
// W is the full operand width (6 * number of chunks).
interface cla6_chain_seq_if #(
    parameter int unsigned W = 24
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, res_ready,
        input  req_ready, res_valid, res_sum, res_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, res_ready,
        output req_ready, res_valid, res_sum, res_cout
    );
endinterface

// File: rtl/cla6_chain_seq.sv
// Wide (NCHUNK x 6-bit) adder built by time-multiplexing one registered
// 6-bit adder. Operands are sliced LSB chunk first; the carry is chained
// between chunks and the assembled sum is returned over a handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   bus      request/result handshake (slave side of cla6_chain_seq_if)
//   busy     high whenever the sequencer is not idle
//   add_a/add_b/add_cin  chunk operands driven to the external adder
//   add_sum/add_cout     registered result returned by the external adder
//   res_ovf  signed overflow of the full-width add (only with the macro)
//
// Optional feature: define CLA6_SEQ_OVF_EN to add the res_ovf output.
//
// Parameters: NCHUNK (1..8) chunks per operand, ADD_LAT (1..4) clocks from
// the operand-issue edge until the adder's sum may be sampled.
module cla6_chain_seq #(
    parameter int unsigned NCHUNK  = 4,
    parameter int unsigned ADD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    cla6_chain_seq_if.slave    bus,
    output logic               busy,
    output logic [5:0]         add_a,
    output logic [5:0]         add_b,
    output logic               add_cin,
    input  logic [5:0]         add_sum,
    input  logic               add_cout
`ifdef CLA6_SEQ_OVF_EN
    ,
    output logic               res_ovf
`endif
);

    localparam int unsigned W     = 6 * NCHUNK;
    localparam int unsigned K_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CNT_W = $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;
    logic               carry_q;
    logic               cout_q;
    logic               valid_q;
    logic [K_W-1:0]     k_q;
    logic [CNT_W-1:0]   cnt_q;
`ifdef CLA6_SEQ_OVF_EN
    logic               ovf_q;
`endif

    // Handshake status decoded straight from the state register.
    assign bus.req_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus.res_valid = valid_q;
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = cout_q;
`ifdef CLA6_SEQ_OVF_EN
    assign res_ovf       = ovf_q;
`endif

    // Sequencer: latch request, issue each chunk, wait out the adder, assemble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
            k_q     <= '0;
            cnt_q   <= '0;
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
`ifdef CLA6_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_q     <= bus.req_a;
                        b_q     <= bus.req_b;
                        carry_q <= bus.req_cin;
                        k_q     <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
`ifdef CLA6_SEQ_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    add_a   <= a_q[6*k_q +: 6];
                    add_b   <= b_q[6*k_q +: 6];
                    add_cin <= carry_q;
                    cnt_q   <= CNT_W'(ADD_LAT);
                    state   <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    // Count of 1 marks the last wait cycle: adder output is valid.
                    if (cnt_q == CNT_W'(1)) begin
                        sum_q[6*k_q +: 6] <= add_sum;
                        carry_q           <= add_cout;
                        if (k_q == K_W'(NCHUNK - 1)) begin
                            cout_q  <= add_cout;
                            valid_q <= 1'b1;
`ifdef CLA6_SEQ_OVF_EN
                            // Same-sign operands whose sum flips sign overflowed.
                            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (add_sum[5] != a_q[W-1]);
`endif
                            state   <= DONE;
                        end else begin
                            k_q   <= k_q + 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla6_chain_seq.sv
// Scoreboard bench for cla6_chain_seq with a behavioural external adder.
module tb_cla6_chain_seq;

    localparam int unsigned NCHUNK  = 4;
    localparam int unsigned ADD_LAT = 2;
    localparam int unsigned W       = 6 * NCHUNK;
    localparam int unsigned W1      = W + 1;
    localparam int unsigned LAT     = NCHUNK * (ADD_LAT + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [5:0] add_a;
    logic [5:0] add_b;
    logic       add_cin;
    logic [5:0] add_sum;
    logic       add_cout;
`ifdef CLA6_SEQ_OVF_EN
    logic       res_ovf;
`endif

    always #5 clk = ~clk;

    cla6_chain_seq_if #(.W(W)) bus ();

    cla6_chain_seq #(.NCHUNK(NCHUNK), .ADD_LAT(ADD_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
`ifdef CLA6_SEQ_OVF_EN
        ,
        .res_ovf  (res_ovf)
`endif
    );

    // External adder: ADD_LAT-1 register stages behind a plain 6-bit add.
    logic [6:0] add_comb;
    assign add_comb = 7'(add_a) + 7'(add_b) + 7'(add_cin);
    generate
        if (ADD_LAT == 1) begin : g_comb
            assign {add_cout, add_sum} = add_comb;
        end else begin : g_pipe
            logic [6:0] stg [ADD_LAT-1];
            always @(posedge clk) begin
                stg[0] <= add_comb;
                for (int i = 1; i < int'(ADD_LAT) - 1; i++) stg[i] <= stg[i-1];
            end
            assign {add_cout, add_sum} = stg[ADD_LAT-2];
        end
    endgenerate

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    longint       cyc      = 0;
    logic [W-1:0] cur_a, cur_b;
    logic         cur_cin;
    longint       acc_edge = 0;
    longint       hs_edge  = 0;
    bit           inflight = 0;
    bit           bp_hold  = 0;
    bit           rr_rand  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Whole-word reference: plain (W+1)-bit arithmetic.
    function automatic exp_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t       r;
        logic [W:0] s;
        s      = W1'(a) + W1'(b) + W1'(cin);
        r.sum  = s[W-1:0];
        r.cout = s[W];
        r.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return r;
    endfunction

    // Carry into chunk j = carry out of adding the low 6*j bits.
    function automatic logic chunk_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input int j);
        logic [63:0] m, s;
        if (j == 0) return cin;
        m = (64'd1 << (6 * j)) - 64'd1;
        s = (64'(a) & m) + (64'(b) & m) + 64'(cin);
        return s[6 * j];
    endfunction

    function automatic logic [5:0] chunk(input logic [W-1:0] v, input int j);
        return v[6 * j +: 6];
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int guard = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        while (bus.req_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (bus.req_ready !== 1'b1) begin
            fail_now("req_accept");
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_edge = cyc;
        cur_a    = a;
        cur_b    = b;
        cur_cin  = cin;
        inflight = 1'b1;
        sb.push_back(ref_add(a, b, cin));
        bus.req_valid = 1'b0;
        bus.req_a     = W'($urandom);
        bus.req_b     = W'($urandom);
        bus.req_cin   = 1'($urandom_range(0, 1));
    endtask

    // Monitor: drives res_ready, checks chunk issue, latency and results.
    always @(negedge clk) begin
        longint d;
        int     j;
        bus.res_ready = bp_hold ? 1'b0 : (rr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (rst) begin
            check("busy", 64'(busy), 64'(inflight));
            check("req_ready", 64'(bus.req_ready), 64'(!inflight));
            check("res_valid", 64'(bus.res_valid), 64'(inflight && (cyc - acc_edge >= LAT)));
            if (inflight) begin
                d = cyc - acc_edge - 1;
                if (d >= 0 && d < LAT) begin
                    j = int'(d / (ADD_LAT + 1));
                    check("add_a", 64'(add_a), 64'(chunk(cur_a, j)));
                    check("add_b", 64'(add_b), 64'(chunk(cur_b, j)));
                    check("add_cin", 64'(add_cin), 64'(chunk_cin(cur_a, cur_b, cur_cin, j)));
                end
            end
            if (bus.res_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    check("res_sum", 64'(bus.res_sum), 64'(sb[0].sum));
                    check("res_cout", 64'(bus.res_cout), 64'(sb[0].cout));
`ifdef CLA6_SEQ_OVF_EN
                    check("res_ovf", 64'(res_ovf), 64'(sb[0].ovf));
`endif
                end
                if (bus.res_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    inflight = 1'b0;
                    hs_edge  = cyc + 1;
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),          64'd0);
        check({tag, "_res_sum"},   64'(bus.res_sum),   64'd0);
        check({tag, "_res_cout"},  64'(bus.res_cout),  64'd0);
        check({tag, "_add_a"},     64'(add_a),         64'd0);
        check({tag, "_add_b"},     64'(add_b),         64'd0);
        check({tag, "_add_cin"},   64'(add_cin),       64'd0);
`ifdef CLA6_SEQ_OVF_EN
        check({tag, "_res_ovf"},   64'(res_ovf),       64'd0);
`endif
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           guard;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = 1'b0;
        #12;
        check_reset_values("rst0");
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors.
        send(24'h123456, 24'h654321, 1'b0);
        send(24'hFFFFFF, 24'h000000, 1'b1);
        send(24'h000FC0, 24'h000040, 1'b0);
        send(24'h7FFFFF, 24'h000001, 1'b0);
        send(24'h800000, 24'h800000, 1'b0);

        // Backpressure: hold res_ready low, queue a second request behind it.
        guard = 0;
        while (inflight && guard < 200) begin @(negedge clk); guard++; end
        bp_hold = 1'b1;
        send(24'h0A0B0C, 24'h102030, 1'b0);
        guard = 0;
        while (bus.res_valid !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        if (bus.res_valid !== 1'b1) fail_now("bp_res_valid");
        fork
            begin
                repeat (5) @(negedge clk);
                #2 bp_hold = 1'b0;
            end
            send(24'h00ABCD, 24'h111111, 1'b1);
        join
        check("bp_accept_gap", 64'(acc_edge - hs_edge), 64'd1);

        // Reset in the WAIT phase of chunk 2, then a fresh request.
        send(W'($urandom), W'($urandom), 1'b1);
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_values("rst_mid");
        sb.delete();
        inflight = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(24'h000001, 24'h000001, 1'b0);

        // Randomised traffic with random consumer stalls.
        rr_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            send(ra, rb, 1'($urandom_range(0, 1)));
        end

        guard = 0;
        while (inflight && guard < 500) begin @(negedge clk); guard++; end
        if (inflight) fail_now("drain");
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cla6_chain_seq.md
Name: cla6_chain_seq

Overview:
- Sequencer that performs a wide (NCHUNK×6-bit) addition by time-multiplexing one registered 6-bit carry-lookahead adder.
- Accepts a wide request over a valid/ready handshake and slices the operands into 6-bit chunks, LSB first.
- Issues each chunk to the adder, chains the carry between chunks, assembles the sum and returns it over a valid/ready result handshake.
- Sits between the requesting logic and the existing 6-bit registered adder instance.

Parameters:
- NCHUNK, 4, number of 6-bit chunks; operand width W = 6*NCHUNK (24 by default); legal range 1..8.
- ADD_LAT, 2, adder latency in clocks from the operand-issue edge to a valid sum/carry; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_a  input  W  operand A.
- req_b  input  W  operand B.
- req_cin  input  1  carry-in.
- res_valid  output  1  result present.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  W  sum.
- res_cout  output  1  carry-out of the top chunk.
- busy  output  1  high in any state other than IDLE.
- add_a  output  6  chunk operand A to the adder.
- add_b  output  6  chunk operand B to the adder.
- add_cin  output  1  chunk carry-in to the adder.
- add_sum  input  6  adder registered sum.
- add_cout  input  1  adder registered carry-out.

Behaviour:
- Reset (rst low, asynchronous) values:
  - state=IDLE; req_ready=1; res_valid=0; busy=0.
  - res_sum=0, res_cout=0.
  - add_a=0, add_b=0, add_cin=0.
  - Internal chunk index, wait counter and carry register = 0.
- Reset asserted mid-operation aborts the addition immediately; no partial result is ever presented.
- State machine IDLE, ISSUE, WAIT, DONE:
  - req_ready = (state==IDLE), decoded directly from the state register.
- IDLE:
  - On req_valid&req_ready at edge E0, latch req_a, req_b and req_cin.
  - Set chunk index k=0 and carry register=req_cin, then go to ISSUE.
  - Operands are ignored when req_valid is low.
- ISSUE (1 cycle):
  - Drive add_a=A[6k+5:6k], add_b=B[6k+5:6k], add_cin=carry register (all registered outputs).
  - Load the wait counter with ADD_LAT, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, sample add_sum into res_sum[6k+5:6k] and add_cout into the carry register at the next edge.
  - If k==NCHUNK-1, go to DONE with res_cout=add_cout; otherwise k=k+1 and go to ISSUE.
  - add_a, add_b and add_cin hold their values during WAIT.
- Throughput: each chunk takes ADD_LAT+1 cycles.
- Latency: res_valid rises on edge E0 + NCHUNK*(ADD_LAT+1), which is 12 edges by default.
- DONE:
  - res_valid=1; res_sum and res_cout hold stable until res_valid&res_ready.
  - On that handshake edge: res_valid=0, go to IDLE, req_ready=1 the following cycle.
  - Back-to-back requests are therefore separated by at least one IDLE cycle.
- res_ready low: stay in DONE indefinitely with outputs frozen; no new request is accepted.
- res_sum is cleared to 0 on acceptance of a new request, so no stale chunks are left.
- Arithmetic is unsigned modulo 2^W; res_cout is the true carry out of bit W-1.

Optional Feature:
- Macro CLA6_SEQ_OVF_EN.
- When defined:
  - Adds output res_ovf (1 bit), reset 0.
  - In the last chunk, res_ovf = (A[W-1]==B[W-1]) && (add_sum[5] != A[W-1]); valid and stable alongside res_valid.
  - Cleared on acceptance of a new request.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- A=0x123456, B=0x654321, cin=0 → res_sum=0x777777, res_cout=0; res_valid exactly 12 edges after acceptance.
- A=0xFFFFFF, B=0x000000, cin=1 → carry ripples through all 4 chunks; res_sum=0x000000, res_cout=1; add_cin=1 observed at every ISSUE.
- A=0x000FC0, B=0x000040, cin=0 → chunk1 carry into chunk2; res_sum=0x001000, res_cout=0.
- Backpressure: res_ready held low 5 cycles after res_valid → res_sum/res_cout/res_valid stable, req_ready=0 throughout; a new req_valid pulse is not accepted until 1 cycle after the handshake.
- Reset pulse during the WAIT of chunk 2 → all outputs return to reset values asynchronously; the next request A=1, B=1 yields res_sum=0x000002 with correct 12-edge latency.
- With CLA6_SEQ_OVF_EN: A=0x7FFFFF, B=0x000001 → res_sum=0x800000, res_ovf=1, res_cout=0; A=0x800000, B=0x800000 → res_sum=0, res_cout=1, res_ovf=1.
